// File: rtl/output_buff.sv
// output_buff: transmit-side four-line serializer.
// Takes one reference word and three signal words through a one-deep shadow
// register and shifts them out LSB first on a 4-bit line bus, one bit per ena
// strobe. Back-to-back frames continue without a gap when the shadow is full
// at the last bit of the current frame.
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous reset, active-high
//   ena      bit strobe, advances the serializer by one bit
//   load     frame-write strobe, accepted only while ready=1
//   dinRef   reference-line frame word
//   dinSigA  signal A frame word
//   dinSigB  signal B frame word
//   dinSigC  signal C frame word
//   ready    shadow register empty
//   dout     line bus {sigC, sigB, sigA, ref}
//   cntout   index of the bit currently on dout
//   busy     frame in flight
//   frameEnd one-cycle pulse when the last bit of a frame is retired
module output_buff #(
  parameter int unsigned NDATA = 128,
  localparam int unsigned NDATA_LOG = $clog2(NDATA)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 load,
  input  logic [NDATA-1:0]     dinRef,
  input  logic [NDATA-1:0]     dinSigA,
  input  logic [NDATA-1:0]     dinSigB,
  input  logic [NDATA-1:0]     dinSigC,
  output logic                 ready,
  output logic [3:0]           dout,
  output logic [NDATA_LOG-1:0] cntout,
  output logic                 busy,
  output logic                 frameEnd
);

  localparam logic [3:0]           IDLE_LEVELS = 4'b0001;
  localparam logic [NDATA_LOG-1:0] LAST_BIT    = NDATA_LOG'(NDATA - 1);

  typedef enum logic [0:0] {IDLE, SHIFT} state_t;

  state_t                      state, state_n;
  // Line order within the packed arrays: [0]=ref, [1]=sigA, [2]=sigB, [3]=sigC.
  logic [3:0][NDATA-1:0]       shadow, shadow_n;
  // Active words hold only the bits not yet driven onto dout.
  logic [3:0][NDATA-1:0]       active, active_n;
  logic                        ready_n;
  logic [3:0]                  dout_n;
  logic [NDATA_LOG-1:0]        cnt_n;
  logic                        busy_n;
  logic                        frame_end_n;
  logic                        take;

  // State register; ready doubles as the inverted shadow-full flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shadow   <= '0;
      active   <= '0;
      ready    <= 1'b1;
      dout     <= IDLE_LEVELS;
      cntout   <= '0;
      busy     <= 1'b0;
      frameEnd <= 1'b0;
    end else begin
      state    <= state_n;
      shadow   <= shadow_n;
      active   <= active_n;
      ready    <= ready_n;
      dout     <= dout_n;
      cntout   <= cnt_n;
      busy     <= busy_n;
      frameEnd <= frame_end_n;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_n     = state;
    shadow_n    = shadow;
    active_n    = active;
    ready_n     = ready;
    dout_n      = dout;
    cnt_n       = cntout;
    busy_n      = busy;
    frame_end_n = 1'b0;
    take        = 1'b0;

    // Load needs an empty shadow, a transfer needs a full one: never both.
    if (load && ready) begin
      shadow_n = {dinSigC, dinSigB, dinSigA, dinRef};
      ready_n  = 1'b0;
    end

    unique case (state)
      IDLE: begin
        dout_n = IDLE_LEVELS;
        busy_n = 1'b0;
        cnt_n  = '0;
        take   = !ready;
      end
      SHIFT: begin
        if (ena) begin
          if (cntout == LAST_BIT) begin
            frame_end_n = 1'b1;
            if (!ready) begin
              take = 1'b1;
            end else begin
              state_n = IDLE;
              dout_n  = IDLE_LEVELS;
              cnt_n   = '0;
              busy_n  = 1'b0;
            end
          end else begin
            cnt_n    = cntout + NDATA_LOG'(1);
            dout_n   = {active[3][0], active[2][0], active[1][0], active[0][0]};
            active_n = {active[3] >> 1, active[2] >> 1, active[1] >> 1, active[0] >> 1};
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Shadow-to-active transfer: bit 0 goes straight to the lines.
    if (take) begin
      active_n = {shadow[3] >> 1, shadow[2] >> 1, shadow[1] >> 1, shadow[0] >> 1};
      dout_n   = {shadow[3][0], shadow[2][0], shadow[1][0], shadow[0][0]};
      ready_n  = 1'b1;
      cnt_n    = '0;
      busy_n   = 1'b1;
      state_n  = SHIFT;
    end
  end

endmodule

// File: tb/tb_output_buff.sv
// Testbench for output_buff: an 8-bit instance for frame, strobe-gap,
// back-to-back and reset cases, and a 128-bit instance for the full-width frame.
module tb_output_buff;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // NDATA = 8 instance
  logic       ena8, load8;
  logic [7:0] r8, a8, b8, c8;
  logic       ready8, busy8, fe8;
  logic [3:0] dout8;
  logic [2:0] cnt8;

  output_buff #(.NDATA(8)) u8 (
    .clk(clk), .rst(rst), .ena(ena8), .load(load8),
    .dinRef(r8), .dinSigA(a8), .dinSigB(b8), .dinSigC(c8),
    .ready(ready8), .dout(dout8), .cntout(cnt8), .busy(busy8), .frameEnd(fe8)
  );

  // NDATA = 128 instance
  logic         ena128, load128;
  logic [127:0] d128;
  logic         ready128, busy128, fe128;
  logic [3:0]   dout128;
  logic [6:0]   cnt128;

  output_buff #(.NDATA(128)) u128 (
    .clk(clk), .rst(rst), .ena(ena128), .load(load128),
    .dinRef(d128), .dinSigA(d128), .dinSigB(d128), .dinSigC(d128),
    .ready(ready128), .dout(dout128), .cntout(cnt128), .busy(busy128), .frameEnd(fe128)
  );

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
  } frame_t;

  typedef struct {
    frame_t f;
    int     gap;        // ena-low cycles before each strobe
    int     load_at;    // bit index at which the next frame is loaded, -1 none
    frame_t nxt;
    frame_t junk;       // loaded two bits later while ready=0, must be ignored
    int     exp_cycles; // cycles from bit 0 on dout to the frameEnd pulse
  } vec_t;

  frame_t sb[$];
  vec_t   tbl[4];
  int     n_vec = 0;
  int     n_err = 0;

  function automatic frame_t mk(logic [7:0] r, logic [7:0] a, logic [7:0] b, logic [7:0] c);
    frame_t f;
    f.r = r; f.a = a; f.b = b; f.c = c;
    return f;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge while idle; returns one negedge after the load edge.
  task automatic load_frame(frame_t f);
    chk("ready_before_load", 32'(ready8), 32'd1);
    load8 = 1'b1;
    r8 = f.r; a8 = f.a; b8 = f.b; c8 = f.c;
    sb.push_back(f);
    @(negedge clk);
    load8 = 1'b0;
    chk("ready_after_load", 32'(ready8), 32'd0);
    chk("idle_dout", 32'(dout8), 32'h1);
    chk("idle_busy", 32'(busy8), 32'd0);
  endtask

  // Plays out every frame in the scoreboard, checking each cycle.
  task automatic play(int gap, int load_at, frame_t nxt, frame_t junk, int exp_cycles);
    frame_t cur;
    int     cyc, fe_at, pend;
    bit     more, did_load, did_junk;
    pend = 0; did_load = 1'b0; did_junk = 1'b0;
    @(negedge clk);
    cur = sb.pop_front();
    do begin
      cyc = 0; fe_at = -1;
      for (int k = 0; k < 8; k++) begin
        for (int p = 0; p <= gap; p++) begin
          chk("dout", 32'(dout8), 32'({cur.c[k], cur.b[k], cur.a[k], cur.r[k]}));
          chk("cntout", 32'(cnt8), 32'(k));
          chk("busy", 32'(busy8), 32'd1);
          if (k == 0 && p == 0 && pend == 0) chk("ready_after_take", 32'(ready8), 32'd1);
          if (fe8 && !(k == 0 && p == 0) && fe_at < 0) fe_at = cyc;
          if (pend != 0) begin
            load8 = 1'b0;
            chk(pend == 1 ? "ready_after_load" : "ready_after_ignored_load", 32'(ready8), 32'd0);
            pend = 0;
          end
          if (!did_load && load_at == k && p == 0) begin
            load8 = 1'b1;
            r8 = nxt.r; a8 = nxt.a; b8 = nxt.b; c8 = nxt.c;
            sb.push_back(nxt);
            did_load = 1'b1; pend = 1;
          end else if (did_load && !did_junk && load_at + 2 == k && p == 0) begin
            load8 = 1'b1;
            r8 = junk.r; a8 = junk.a; b8 = junk.b; c8 = junk.c;
            did_junk = 1'b1; pend = 2;
          end
          ena8 = (p == gap);
          @(negedge clk);
          cyc++;
        end
      end
      ena8 = 1'b0;
      if (fe8 && fe_at < 0) fe_at = cyc;
      chk("frame_end_cycle", 32'(fe_at), 32'(exp_cycles));
      more = (sb.size() > 0);
      if (more) begin
        cur = sb.pop_front();
      end else begin
        chk("end_dout", 32'(dout8), 32'h1);
        chk("end_busy", 32'(busy8), 32'd0);
        chk("end_cntout", 32'(cnt8), 32'd0);
        chk("end_ready", 32'(ready8), 32'd1);
      end
    end while (more);
    @(negedge clk);
    chk("frame_end_single_pulse", 32'(fe8), 32'd0);
  endtask

  initial begin
    bit found;
    rst = 1'b1; ena8 = 1'b0; load8 = 1'b0; r8 = '0; a8 = '0; b8 = '0; c8 = '0;
    ena128 = 1'b0; load128 = 1'b0; d128 = '0;

    tbl[0] = '{mk(8'hA5, 8'h0F, 8'hFF, 8'h00), 0, -1, mk(8'h00, 8'h00, 8'h00, 8'h00),
               mk(8'h00, 8'h00, 8'h00, 8'h00), 8};
    tbl[1] = '{mk(8'h3C, 8'hC3, 8'h5A, 8'h96), 2, -1, mk(8'h00, 8'h00, 8'h00, 8'h00),
               mk(8'h00, 8'h00, 8'h00, 8'h00), 24};
    tbl[2] = '{mk(8'h81, 8'h7E, 8'h01, 8'h80), 0, 2, mk(8'hE7, 8'h18, 8'hAA, 8'h55),
               mk(8'h00, 8'hFF, 8'h00, 8'hFF), 8};
    tbl[3] = '{mk(8'h12, 8'h34, 8'h56, 8'h78), 1, 5, mk(8'h9A, 8'hBC, 8'hDE, 8'hF0),
               mk(8'hFF, 8'h00, 8'hFF, 8'h00), 16};

    // Reset values
    @(negedge clk);
    chk("rst_dout", 32'(dout8), 32'h1);
    chk("rst_ready", 32'(ready8), 32'd1);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_cntout", 32'(cnt8), 32'd0);
    chk("rst_frame_end", 32'(fe8), 32'd0);
    chk("rst_dout_128", 32'(dout128), 32'h1);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven frames
    for (int v = 0; v < 4; v++) begin
      load_frame(tbl[v].f);
      play(tbl[v].gap, tbl[v].load_at, tbl[v].nxt, tbl[v].junk, tbl[v].exp_cycles);
    end

    // Reset mid-frame at cntout=3 with a second frame waiting in the shadow
    load_frame(mk(8'hFF, 8'hFF, 8'hFF, 8'hFF));
    @(negedge clk);
    load8 = 1'b1; r8 = 8'h55; a8 = 8'h55; b8 = 8'h55; c8 = 8'h55;
    ena8 = 1'b1;
    @(negedge clk);
    load8 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (cnt8 == 3'd3) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("reached_cntout_3", 32'(found), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_dout", 32'(dout8), 32'h1);
    chk("midrst_cntout", 32'(cnt8), 32'd0);
    chk("midrst_busy", 32'(busy8), 32'd0);
    chk("midrst_ready", 32'(ready8), 32'd1);
    ena8 = 1'b0;
    @(negedge clk);
    chk("midrst_frame_end", 32'(fe8), 32'd0);
    rst = 1'b0;
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("postrst_busy", 32'(busy8), 32'd0);
      chk("postrst_frame_end", 32'(fe8), 32'd0);
      chk("postrst_dout", 32'(dout8), 32'h1);
    end

    // NDATA=128, all ones, ena held high
    load128 = 1'b1; d128 = '1;
    @(negedge clk);
    load128 = 1'b0; ena128 = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (busy128) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("busy_128", 32'(found), 32'd1);
    for (int i = 0; i < 128; i++) begin
      chk("dout_128", 32'(dout128), 32'hF);
      chk("cntout_128", 32'(cnt128), 32'(i));
      chk("frame_end_128_early", 32'(fe128), 32'd0);
      @(negedge clk);
    end
    ena128 = 1'b0;
    chk("frame_end_128", 32'(fe128), 32'd1);
    chk("end_dout_128", 32'(dout128), 32'h1);
    chk("end_busy_128", 32'(busy128), 32'd0);
    @(negedge clk);
    chk("frame_end_128_single", 32'(fe128), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
